// File: rtl/input_logic.sv
// input_logic: front-panel input block.
// Synchronises the raw switches and push-buttons, debounces each button,
// turns debounced presses into one-cycle events, latches the switch value
// into DIN on a LOAD press, and runs a two-state Run/DONE handshake.
module input_logic #(
    parameter int DATA_W    = 10,
    parameter int DB_CYCLES = 500000
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic [DATA_W-1:0] SW,
    input  logic              KEY_LOADb,
    input  logic              KEY_RUNb,
    input  logic              KEY_PEEKb,
    input  logic              DONE,
    output logic [DATA_W-1:0] DIN,
    output logic              RUN,
    output logic              PEEKb,
    output logic              LOAD_P,
    output logic              BUSY
);

    // Key index map inside the packed key vectors
    localparam int NKEYS    = 3;
    localparam int KEY_LOAD = 0;
    localparam int KEY_RUN  = 1;
    localparam int KEY_PEEK = 2;

    // Counter only has to reach DB_CYCLES-1, so ceil(log2(DB_CYCLES)) bits suffice
    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Run/DONE handshake states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [NKEYS-1:0]  w_key_raw;
    logic [NKEYS-1:0]  r_key_s1;
    logic [NKEYS-1:0]  r_key_s2;
    logic [DATA_W-1:0] r_sw_s1;
    logic [DATA_W-1:0] r_sw_s2;
    logic [NKEYS-1:0]  w_db_state;
    logic [NKEYS-1:0]  w_press;
    logic [0:0]        r_fsm;
    logic [0:0]        w_fsm_next;
    logic              w_busy;
    logic [DATA_W-1:0] r_din;
    logic              r_load_p;
    logic              r_peekb;

    assign w_key_raw = {KEY_PEEKb, KEY_RUNb, KEY_LOADb};

    // Two-flop synchronisers; keys reset to the released level
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= w_key_raw;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            logic [CNT_W-1:0] r_cnt;
            logic             r_state;
            logic             r_prev;

            // Debounce: a new level is accepted only after DB_CYCLES consecutive
            // mismatching samples; any sample agreeing with the current state restarts it
            always_ff @(posedge CLK or negedge RSTb) begin
                if (!RSTb) begin
                    r_cnt   <= '0;
                    r_state <= 1'b1;
                    r_prev  <= 1'b1;
                end else begin
                    r_prev <= r_state;
                    if (r_key_s2[gi] == r_state) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= r_key_s2[gi];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_db_state[gi] = r_state;
            // Press event: debounced level just fell 1->0; releases make no event
            assign w_press[gi]    = r_prev & ~r_state;
        end
    endgenerate

    assign w_busy = (r_fsm == ST_WAIT);

    // Next-state logic: DONE has priority in WAIT, RUN presses are ignored there
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE: if (w_press[KEY_RUN]) w_fsm_next = ST_WAIT;
            ST_WAIT: if (DONE)             w_fsm_next = ST_IDLE;
            default:                       w_fsm_next = ST_IDLE;
        endcase
    end

    // State register; reset drops RUN/BUSY immediately
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // DIN latch and peek level; LOAD presses are dropped while busy so DIN
    // stays stable for the whole operation
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_din    <= '0;
            r_load_p <= 1'b0;
            r_peekb  <= 1'b1;
        end else begin
            r_load_p <= w_press[KEY_LOAD] & ~w_busy;
            if (w_press[KEY_LOAD] && !w_busy) begin
                r_din <= r_sw_s2;
            end
            r_peekb <= w_db_state[KEY_PEEK];
        end
    end

    assign DIN    = r_din;
    assign LOAD_P = r_load_p;
    assign PEEKb  = r_peekb;
    assign RUN    = w_busy;
    assign BUSY   = w_busy;

endmodule

// File: tb/tb_input_logic.sv
// Testbench for input_logic: directed scenarios followed by randomized key,
// switch and DONE activity. A window-based reference model predicts every
// output each cycle; a separate monitor pops the predictions and compares.
module tb_input_logic;

    localparam int DW = 10;
    localparam int DB = 4;

    logic          CLK = 1'b0;
    logic          RSTb;
    logic [DW-1:0] SW;
    logic          KEY_LOADb;
    logic          KEY_RUNb;
    logic          KEY_PEEKb;
    logic          DONE;
    logic [DW-1:0] DIN;
    logic          RUN;
    logic          PEEKb;
    logic          LOAD_P;
    logic          BUSY;

    input_logic #(.DATA_W(DW), .DB_CYCLES(DB)) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .SW        (SW),
        .KEY_LOADb (KEY_LOADb),
        .KEY_RUNb  (KEY_RUNb),
        .KEY_PEEKb (KEY_PEEKb),
        .DONE      (DONE),
        .DIN       (DIN),
        .RUN       (RUN),
        .PEEKb     (PEEKb),
        .LOAD_P    (LOAD_P),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] din;
        logic          run;
        logic          peekb;
        logic          load_p;
        logic          busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: raw samples per edge (newest first), debounced
    // levels, pending press events and the expected outputs
    logic [2:0]    key_hist[$];
    logic [DW-1:0] sw_hist[$];
    logic [2:0]    m_db;
    logic [2:0]    m_pend;
    logic [DW-1:0] m_din;
    logic          m_busy;
    logic          m_peekb;
    logic          m_loadp;

    int   lp_cnt   = 0;
    int   lp_tick  = -1;
    int   rise_cnt = 0;
    int   tick_no  = 0;
    logic prev_run = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.din    = m_din;
        e.run    = m_busy;
        e.peekb  = m_peekb;
        e.load_p = m_loadp;
        e.busy   = m_busy;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        key_hist.delete();
        sw_hist.delete();
        for (int i = 0; i < DB + 2; i++) begin
            key_hist.push_back(3'b111);
            sw_hist.push_back('0);
        end
        m_db    = 3'b111;
        m_pend  = 3'b000;
        m_din   = '0;
        m_busy  = 1'b0;
        m_peekb = 1'b1;
        m_loadp = 1'b0;
    endfunction

    // One clock edge of the model. A key's debounced level flips once the
    // last DB synchronised samples (raw samples two edges old) all disagree
    // with it; a 1->0 flip becomes a press acted on at the following edge.
    function automatic void model_step();
        logic stable;
        if (!RSTb) begin
            model_reset();
        end else begin
            key_hist.push_front({KEY_PEEKb, KEY_RUNb, KEY_LOADb});
            sw_hist.push_front(SW);
            while (key_hist.size() > DB + 2) void'(key_hist.pop_back());
            while (sw_hist.size() > DB + 2)  void'(sw_hist.pop_back());

            m_loadp = m_pend[0] && !m_busy;
            if (m_loadp) m_din = sw_hist[2];
            m_peekb = m_db[2];
            if (!m_busy)   m_busy = m_pend[1];
            else if (DONE) m_busy = 1'b0;

            for (int k = 0; k < 3; k++) begin
                stable = 1'b1;
                for (int j = 2; j < DB + 2; j++) begin
                    if (key_hist[j][k] == m_db[k]) stable = 1'b0;
                end
                m_pend[k] = 1'b0;
                if (stable) begin
                    m_db[k]   = ~m_db[k];
                    m_pend[k] = ~m_db[k];
                end
            end
        end
        push_exp();
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        tick_no++;
        if (LOAD_P === 1'b1) begin
            lp_cnt++;
            lp_tick = tick_no;
        end
        if (RUN === 1'b1 && prev_run !== 1'b1) rise_cnt++;
        prev_run = RUN;
    endtask

    // Assert reset mid-cycle, check RUN/BUSY drop at once, then release
    task automatic mid_reset(input int hold);
        RSTb      = 1'b0;
        KEY_LOADb = 1'b1;
        KEY_RUNb  = 1'b1;
        KEY_PEEKb = 1'b1;
        DONE      = 1'b0;
        #1;
        chk("run_async_reset", 32'(RUN), 32'd0);
        chk("busy_async_reset", 32'(BUSY), 32'd0);
        sb.delete();
        model_reset();
        push_exp();
        prev_run = 1'b0;
        repeat (hold) tick();
        RSTb = 1'b1;
    endtask

    // Monitor: compare every predicted cycle on the falling edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("DIN",    32'(DIN),    32'(e.din));
                chk("RUN",    32'(RUN),    32'(e.run));
                chk("PEEKb",  32'(PEEKb),  32'(e.peekb));
                chk("LOAD_P", 32'(LOAD_P), 32'(e.load_p));
                chk("BUSY",   32'(BUSY),   32'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        bit bouncy;
        model_reset();

        // Reset with random inputs
        RSTb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            SW        = DW'($urandom());
            KEY_LOADb = 1'($urandom());
            KEY_RUNb  = 1'($urandom());
            KEY_PEEKb = 1'($urandom());
            DONE      = 1'($urandom());
            tick();
        end
        RSTb = 1'b1; KEY_LOADb = 1'b1; KEY_RUNb = 1'b1; KEY_PEEKb = 1'b1; DONE = 1'b0;
        repeat (10) tick();
        chk("reset_din", 32'(DIN), 32'd0);
        chk("reset_run", 32'(RUN), 32'd0);
        chk("reset_peekb", 32'(PEEKb), 32'd1);

        // Load: one pulse 7 cycles after the press edge
        lp_cnt = 0; tick_no = 0;
        SW = 10'h2A5; KEY_LOADb = 1'b0;
        repeat (20) tick();
        chk("load_pulse_count", 32'(lp_cnt), 32'd1);
        chk("load_latency", 32'(lp_tick), 32'd7);
        chk("load_din", 32'(DIN), 32'h2A5);
        KEY_LOADb = 1'b1; SW = 10'h0F0;
        repeat (10) tick();
        chk("din_hold", 32'(DIN), 32'h2A5);

        // Bounce on RUN, then a stable press
        rise_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            KEY_RUNb = ((i / 2) % 2 == 1);
            tick();
        end
        chk("bounce_no_run", 32'(rise_cnt), 32'd0);
        KEY_RUNb = 1'b0;
        repeat (6) tick();
        chk("run_before_debounce", 32'(RUN), 32'd0);
        tick();
        chk("run_after_debounce", 32'(RUN), 32'd1);
        repeat (13) tick();
        chk("run_single_rise", 32'(rise_cnt), 32'd1);

        // Hold WAIT for 50 cycles, with a second RUN press in the middle
        KEY_RUNb = 1'b1;
        for (int i = 0; i < 50; i++) begin
            KEY_RUNb = !(i >= 10 && i < 20);
            tick();
        end
        chk("wait_run_held", 32'(RUN), 32'd1);
        chk("wait_busy_held", 32'(BUSY), 32'd1);
        chk("wait_no_extra_op", 32'(rise_cnt), 32'd1);

        // LOAD press while busy is dropped
        SW = 10'h155; KEY_LOADb = 1'b0; lp_cnt = 0;
        repeat (10) tick();
        KEY_LOADb = 1'b1;
        repeat (10) tick();
        chk("busy_load_din", 32'(DIN), 32'h2A5);
        chk("busy_load_pulse", 32'(lp_cnt), 32'd0);

        // DONE pulse ends the operation
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        chk("done_run_low", 32'(RUN), 32'd0);
        chk("done_busy_low", 32'(BUSY), 32'd0);
        KEY_LOADb = 1'b0;
        repeat (10) tick();
        chk("load_after_done", 32'(DIN), 32'h155);
        KEY_LOADb = 1'b1;
        repeat (10) tick();

        // Peek level follows the key after the full latency both ways
        KEY_PEEKb = 1'b0;
        repeat (6) tick();
        chk("peek_before", 32'(PEEKb), 32'd1);
        tick();
        chk("peek_low", 32'(PEEKb), 32'd0);
        repeat (5) tick();
        KEY_PEEKb = 1'b1;
        repeat (6) tick();
        chk("peek_still_low", 32'(PEEKb), 32'd0);
        tick();
        chk("peek_released", 32'(PEEKb), 32'd1);

        // Reset while in WAIT
        KEY_RUNb = 1'b0;
        repeat (8) tick();
        chk("midop_busy", 32'(BUSY), 32'd1);
        KEY_RUNb = 1'b1;
        repeat (3) tick();
        mid_reset(3);
        repeat (10) tick();
        chk("midop_idle_run", 32'(RUN), 32'd0);
        chk("midop_idle_busy", 32'(BUSY), 32'd0);

        // Randomized phase: alternating bouncy and clean key activity
        bouncy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) bouncy = 1'($urandom_range(0, 1));
            SW   = DW'($urandom());
            DONE = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, bouncy ? 2 : 15) == 0) KEY_LOADb = ~KEY_LOADb;
            if ($urandom_range(0, bouncy ? 2 : 15) == 0) KEY_RUNb  = ~KEY_RUNb;
            if ($urandom_range(0, bouncy ? 2 : 15) == 0) KEY_PEEKb = ~KEY_PEEKb;
            if ($urandom_range(0, 999) == 0) mid_reset(3);
            else tick();
        end

        repeat (3) tick();
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
